sprite_physics_mover: RTL and testbench



---
 rtl/sprite_physics_mover_if.sv | 46 ++++
 rtl/sprite_physics_mover.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_sprite_physics_mover.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_physics_mover_if.sv
// Sprite mover signal bundle: button levels and tile map in, committed sprite
// state out. The master side is whoever owns the buttons and the map (top
// level or bench); the slave side is the mover itself.
interface sprite_physics_mover_if #(
  parameter int ROWS = 12,
  parameter int COLS = 17
);

  // Inputs to the mover
  logic                            left;
  logic                            right;
  logic                            jump;
  logic [0:ROWS-1][0:COLS-1][7:0]  background;

  // Outputs from the mover
  logic signed [31:0]              sprite_x;
  logic signed [31:0]              sprite_y;
  logic                            grounded;
  logic                            facing_left;
  logic                            busy;

  modport master (
    output left,
    output right,
    output jump,
    output background,
    input  sprite_x,
    input  sprite_y,
    input  grounded,
    input  facing_left,
    input  busy
  );

  modport slave (
    input  left,
    input  right,
    input  jump,
    input  background,
    output sprite_x,
    output sprite_y,
    output grounded,
    output facing_left,
    output busy
  );

endinterface

// File: rtl/sprite_physics_mover.sv
// Sprite physics mover: owns one sprite's position and velocity, steps it one
// pixel per cycle against the tile map on every frame tick, and commits the
// new x/y pair atomically for the renderer.
// Optional build macro: VARIABLE_JUMP_EN -- when defined, releasing jump while
// rising halves the upward speed each tick, giving a shorter hop.
module sprite_physics_mover #(
  parameter int          ROWS        = 12,
  parameter int          COLS        = 17,
  parameter int          BLOCK_WIDTH = 40,
  parameter int          SPRITE_W    = 40,
  parameter int          SPRITE_H    = 40,
  parameter logic [7:0]  BDR         = 8'd0,
  parameter logic [7:0]  SKY         = 8'd1,
  parameter logic [7:0]  BLK         = 8'd2,
  parameter logic [7:0]  GND         = 8'd3,
  parameter logic [7:0]  TKN         = 8'd4,
  parameter int          TICK_DIV    = 416667,
  parameter int          ACCEL       = 1,
  parameter int          MAX_VX      = 4,
  parameter int          GRAVITY     = 1,
  parameter int          MAX_VY      = 8,
  parameter int          JUMP_V      = 12,
  parameter int          START_X     = 40,
  parameter int          START_Y     = 360
) (
  input  logic                  vga_clock,
  input  logic                  reset,
  sprite_physics_mover_if.slave bus
);

  // Map geometry and index widths
  localparam int MAP_W   = COLS * BLOCK_WIDTH;
  localparam int MAP_H   = ROWS * BLOCK_WIDTH;
  localparam int MAP_MAX = (MAP_W > MAP_H) ? MAP_W : MAP_H;
  localparam int CW      = (MAP_MAX > 1) ? $clog2(MAP_MAX) : 1;
  localparam int CIW     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RIW     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Velocity constants at working width
  localparam logic signed [15:0] ACCEL_S   = 16'(ACCEL);
  localparam logic signed [15:0] MAX_VX_S  = 16'(MAX_VX);
  localparam logic signed [15:0] GRAVITY_S = 16'(GRAVITY);
  localparam logic signed [15:0] MAX_VY_S  = 16'(MAX_VY);
  localparam logic signed [15:0] JUMP_V_S  = 16'(JUMP_V);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_MOVE_X,
    S_MOVE_Y,
    S_PROBE,
    S_COMMIT
  } state_t;

  // Frame-tick divider
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick;

  // Control and physics state
  state_t             state_q, state_d;
  logic signed [31:0] x_q, x_d;
  logic signed [31:0] y_q, y_d;
  logic signed [31:0] wx_q, wx_d;
  logic signed [31:0] wy_q, wy_d;
  logic signed [15:0] vx_q, vx_d;
  logic signed [15:0] vy_q, vy_d;
  logic [15:0]        steps_q, steps_d;
  logic               grounded_q, grounded_d;
  logic               facing_left_q, facing_left_d;
  logic               jump_prev_q, jump_prev_d;
  logic               busy_q, busy_d;

  // LATCH-cycle temporaries
  logic signed [15:0] vx_new;
  logic signed [15:0] vy_rel;
  logic signed [15:0] vy_new;

  // Two shared collision probes: pixel coordinates and their solidity
  logic signed [31:0] probe_x [2];
  logic signed [31:0] probe_y [2];
  logic [1:0]         probe_solid;

  function automatic logic [15:0] mag(input logic signed [15:0] v);
    return (v < 16'sd0) ? 16'(-v) : 16'(v);
  endfunction

  // Tick pulses for one cycle when the divider wraps
  assign tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  // Divider register; keeps running regardless of FSM activity
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Place the two probe points for the current state: leading edge while
  // moving, the row just beneath the feet otherwise
  always_comb begin
    probe_x[0] = wx_q;
    probe_x[1] = wx_q + SPRITE_W - 1;
    probe_y[0] = wy_q + SPRITE_H;
    probe_y[1] = wy_q + SPRITE_H;
    case (state_q)
      S_MOVE_X: begin
        probe_x[0] = (vx_q < 16'sd0) ? wx_q - 32'sd1 : wx_q + SPRITE_W;
        probe_x[1] = probe_x[0];
        probe_y[0] = wy_q;
        probe_y[1] = wy_q + SPRITE_H - 1;
      end
      S_MOVE_Y: begin
        probe_y[0] = (vy_q < 16'sd0) ? wy_q - 32'sd1 : wy_q + SPRITE_H;
        probe_y[1] = probe_y[0];
      end
      default: begin
      end
    endcase
  end

  // Tile lookup per probe. Anything off the map counts as solid so the
  // sprite can never leave it; unrecognised tile codes are also treated as
  // solid so a corrupted map cannot open a hole.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_probe
      logic            in_map;
      logic [CW-1:0]   px_u;
      logic [CW-1:0]   py_u;
      logic [CIW-1:0]  col_idx;
      logic [RIW-1:0]  row_idx;
      logic [7:0]      code;
      logic            known_solid;
      logic            passable;

      assign in_map      = (probe_x[gi] >= 32'sd0) && (probe_x[gi] < MAP_W) &&
                           (probe_y[gi] >= 32'sd0) && (probe_y[gi] < MAP_H);
      assign px_u        = probe_x[gi][CW-1:0];
      assign py_u        = probe_y[gi][CW-1:0];
      assign col_idx     = CIW'(px_u / CW'(BLOCK_WIDTH));
      assign row_idx     = RIW'(py_u / CW'(BLOCK_WIDTH));
      assign code        = bus.background[row_idx][col_idx];
      assign known_solid = (code == BDR) || (code == BLK) || (code == GND);
      assign passable    = (code == SKY) || (code == TKN);
      assign probe_solid[gi] = !in_map || known_solid || !passable;
    end
  endgenerate

  // Next-state and datapath logic for the per-tick update sequence
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    wx_d          = wx_q;
    wy_d          = wy_q;
    vx_d          = vx_q;
    vy_d          = vy_q;
    steps_d       = steps_q;
    grounded_d    = grounded_q;
    facing_left_d = facing_left_q;
    jump_prev_d   = jump_prev_q;
    vx_new        = vx_q;
    vy_rel        = vy_q;
    vy_new        = vy_q;

    case (state_q)
      S_IDLE: begin
        if (tick) state_d = S_LATCH;
      end

      S_LATCH: begin
        wx_d        = x_q;
        wy_d        = y_q;
        jump_prev_d = bus.jump;

        // Horizontal: accelerate toward the pressed side, else decay to rest
        if (bus.left ^ bus.right) begin
          facing_left_d = bus.left;
          if (bus.left) begin
            vx_new = vx_q - ACCEL_S;
            if (vx_new < -MAX_VX_S) vx_new = -MAX_VX_S;
          end else begin
            vx_new = vx_q + ACCEL_S;
            if (vx_new > MAX_VX_S) vx_new = MAX_VX_S;
          end
        end else if (vx_q > 16'sd0) begin
          vx_new = (vx_q > ACCEL_S) ? vx_q - ACCEL_S : 16'sd0;
        end else if (vx_q < 16'sd0) begin
          vx_new = (vx_q < -ACCEL_S) ? vx_q + ACCEL_S : 16'sd0;
        end

`ifdef VARIABLE_JUMP_EN
        // Cut the ascent short when jump is let go while still rising
        if (!bus.jump && (vy_q < 16'sd0)) vy_rel = vy_q / 16'sd2;
`else
        vy_rel = vy_q;
`endif

        // Vertical: a fresh press while standing launches, else gravity
        if (bus.jump && !jump_prev_q && grounded_q) begin
          vy_new = -JUMP_V_S;
        end else begin
          vy_new = vy_rel + GRAVITY_S;
          if (vy_new > MAX_VY_S) vy_new = MAX_VY_S;
        end

        vx_d = vx_new;
        vy_d = vy_new;

        if (vx_new != 16'sd0) begin
          state_d = S_MOVE_X;
          steps_d = mag(vx_new);
        end else if (vy_new != 16'sd0) begin
          state_d = S_MOVE_Y;
          steps_d = mag(vy_new);
        end else begin
          state_d = S_PROBE;
        end
      end

      S_MOVE_X: begin
        if (probe_solid != 2'b00) begin
          vx_d = 16'sd0;
        end else begin
          wx_d = (vx_q < 16'sd0) ? wx_q - 32'sd1 : wx_q + 32'sd1;
        end
        if ((probe_solid != 2'b00) || (steps_q == 16'd1)) begin
          if (vy_q != 16'sd0) begin
            state_d = S_MOVE_Y;
            steps_d = mag(vy_q);
          end else begin
            state_d = S_PROBE;
          end
        end else begin
          steps_d = steps_q - 16'd1;
        end
      end

      S_MOVE_Y: begin
        // Landing and head bumps both kill vertical speed
        if (probe_solid != 2'b00) begin
          vy_d = 16'sd0;
        end else begin
          wy_d = (vy_q < 16'sd0) ? wy_q - 32'sd1 : wy_q + 32'sd1;
        end
        if ((probe_solid != 2'b00) || (steps_q == 16'd1)) begin
          state_d = S_PROBE;
        end else begin
          steps_d = steps_q - 16'd1;
        end
      end

      S_PROBE: begin
        grounded_d = (probe_solid != 2'b00);
        state_d    = S_COMMIT;
      end

      S_COMMIT: begin
        // Both coordinates change on the same edge so no torn pair is seen
        x_d     = wx_q;
        y_d     = wy_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // FSM and physics registers; reset abandons any update in flight
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      x_q           <= START_X;
      y_q           <= START_Y;
      wx_q          <= START_X;
      wy_q          <= START_Y;
      vx_q          <= 16'sd0;
      vy_q          <= 16'sd0;
      steps_q       <= 16'd0;
      grounded_q    <= 1'b0;
      facing_left_q <= 1'b0;
      jump_prev_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      wx_q          <= wx_d;
      wy_q          <= wy_d;
      vx_q          <= vx_d;
      vy_q          <= vy_d;
      steps_q       <= steps_d;
      grounded_q    <= grounded_d;
      facing_left_q <= facing_left_d;
      jump_prev_q   <= jump_prev_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.sprite_x    = x_q;
  assign bus.sprite_y    = y_q;
  assign bus.grounded    = grounded_q;
  assign bus.facing_left = facing_left_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_sprite_physics_mover.sv
// Directed bench for sprite_physics_mover: walks the sprite across a small
// hand-built map and checks committed positions against hand-derived values.
module tb_sprite_physics_mover;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   upd_num   = 0;

  logic [0:11][0:16][7:0] tile_map;

  sprite_physics_mover_if #(.ROWS(12), .COLS(17)) bus_a ();
  sprite_physics_mover_if #(.ROWS(12), .COLS(17)) bus_b ();

  sprite_physics_mover #(.TICK_DIV(20)) dut_a (
    .vga_clock (clk),
    .reset     (rst),
    .bus       (bus_a)
  );

  sprite_physics_mover #(.TICK_DIV(3)) dut_b (
    .vga_clock (clk),
    .reset     (rst),
    .bus       (bus_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Wait for one full update on dut_a (busy rise then fall), bounded
  task automatic wait_update();
    int n;
    n = 0;
    while (bus_a.busy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus_a.busy !== 1'b1) begin
      total_cnt++;
      $display("FAIL upd_start: busy=%0b after %0d cycles, expected 1", bus_a.busy, n);
      return;
    end
    n = 0;
    while (bus_a.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus_a.busy !== 1'b0) begin
      total_cnt++;
      $display("FAIL upd_end: busy=%0b after %0d cycles, expected 0", bus_a.busy, n);
      return;
    end
    upd_num++;
    $display("update %0d: x=%0d y=%0d grounded=%0b facing_left=%0b",
             upd_num, bus_a.sprite_x, bus_a.sprite_y, bus_a.grounded, bus_a.facing_left);
  endtask

  // Cycles between successive busy rises on dut_b
  task automatic measure_b(output int gap);
    int n;
    n = 0;
    while (bus_b.busy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (bus_b.busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (bus_b.busy !== 1'b0 && n < 50);
    do begin @(negedge clk); n++; end while (bus_b.busy !== 1'b1 && n < 50);
    gap = n;
    $display("dut_b update gap: %0d cycles", gap);
  endtask

  int exp_r[6]  = '{41, 43, 46, 50, 54, 58};
  int exp_rel[4] = '{61, 63, 64, 64};
  int exp_w[7]  = '{65, 67, 70, 74, 78, 80, 80};

  initial begin
    int min_y;
    int landed;
    int gap;
    int exp_apex2;
    int n;

    // Map: border ring, ground rows 10-11, a wall block at (9,3), tokens at (7,2),(8,2)
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < 17; c++) begin
        tile_map[r][c] = 8'd1;
        if (r == 0 || c == 0 || c == 16) tile_map[r][c] = 8'd0;
        if (r >= 10) tile_map[r][c] = 8'd3;
      end
    end
    tile_map[9][3] = 8'd2;
    tile_map[8][2] = 8'd4;
    tile_map[7][2] = 8'd4;

    bus_a.background = tile_map;
    bus_b.background = tile_map;
    bus_a.left = 1'b0; bus_a.right = 1'b0; bus_a.jump = 1'b0;
    bus_b.left = 1'b0; bus_b.right = 1'b0; bus_b.jump = 1'b0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_x", bus_a.sprite_x, 40);
    check("rst_y", bus_a.sprite_y, 360);
    check("rst_busy", bus_a.busy, 0);
    check("rst_grounded", bus_a.grounded, 0);
    check("rst_facing", bus_a.facing_left, 0);

    // First tick with no input: lands on the ground row without moving
    wait_update();
    check("idle_grounded", bus_a.grounded, 1);
    check("idle_y", bus_a.sprite_y, 360);
    check("idle_x", bus_a.sprite_x, 40);

    // Push left into the border column
    bus_a.left = 1'b1;
    wait_update();
    check("border_x", bus_a.sprite_x, 40);
    check("border_facing", bus_a.facing_left, 1);
    bus_a.left = 1'b0;

    // Accelerate right for six ticks
    bus_a.right = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_update();
      check($sformatf("accel_x%0d", i), bus_a.sprite_x, exp_r[i]);
    end
    check("accel_facing", bus_a.facing_left, 0);

    // Release and coast to rest
    bus_a.right = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_update();
      check($sformatf("decay_x%0d", i), bus_a.sprite_x, exp_rel[i]);
    end

    // Run into the wall block in column 3
    bus_a.right = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wait_update();
      check($sformatf("wall_x%0d", i), bus_a.sprite_x, exp_w[i]);
    end
    check("wall_y", bus_a.sprite_y, 360);
    bus_a.right = 1'b0;
    wait_update();
    check("wall_rest_x", bus_a.sprite_x, 80);

    // Fixed jump with jump held throughout, through the token tiles
    bus_a.jump = 1'b1;
    min_y = 1000;
    landed = 0;
    for (int k = 0; k < 60 && landed == 0; k++) begin
      wait_update();
      if (bus_a.sprite_y < min_y) min_y = bus_a.sprite_y;
      if (k > 0 && bus_a.grounded == 1'b1 && bus_a.sprite_y == 360) landed = 1;
    end
    check("jump1_apex", min_y, 282);
    check("jump1_landed", landed, 1);
    for (int i = 0; i < 3; i++) begin
      wait_update();
      check($sformatf("hold_norejump_y%0d", i), bus_a.sprite_y, 360);
    end
    bus_a.jump = 1'b0;
    wait_update();

    // Jump held two ticks then released
`ifdef VARIABLE_JUMP_EN
    exp_apex2 = 332;
`else
    exp_apex2 = 282;
`endif
    min_y = 1000;
    landed = 0;
    for (int k = 0; k < 60 && landed == 0; k++) begin
      bus_a.jump = (k < 2) ? 1'b1 : 1'b0;
      wait_update();
      if (bus_a.sprite_y < min_y) min_y = bus_a.sprite_y;
      if (k > 0 && bus_a.grounded == 1'b1 && bus_a.sprite_y == 360) landed = 1;
    end
    check("jump2_apex", min_y, exp_apex2);
    check("jump2_landed", landed, 1);
    check("jump2_x", bus_a.sprite_x, 80);

    // Reset in the middle of a horizontal move
    bus_a.left = 1'b1;
    n = 0;
    while (bus_a.busy !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    check("abort_pre_x", bus_a.sprite_x, 80);
    rst = 1'b1;
    @(negedge clk);
    check("abort_x", bus_a.sprite_x, 40);
    check("abort_y", bus_a.sprite_y, 360);
    check("abort_busy", bus_a.busy, 0);
    check("abort_grounded", bus_a.grounded, 0);
    rst = 1'b0;
    bus_a.left = 1'b0;
    wait_update();
    check("post_abort_x", bus_a.sprite_x, 40);
    check("post_abort_y", bus_a.sprite_y, 360);
    check("post_abort_grounded", bus_a.grounded, 1);

    // TICK_DIV=3: the tick landing mid-update is dropped, counter free-runs
    measure_b(gap);
    check("drop_gap0", gap, 6);
    measure_b(gap);
    check("drop_gap1", gap, 6);
    check("drop_y", bus_b.sprite_y, 360);
    check("drop_x", bus_b.sprite_x, 40);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
